// File: rtl/contador_modn_updown_cascata.sv
// ---------------------------------------------------------------------------
// contador_modn_updown_cascata
//
// Multi-digit modulo-MODULUS up/down counter. It has a synchronous parallel
// load with per-digit clamping, a count enable, a combinational terminal
// count, a carry-out for chaining further instances, and a registered
// one-cycle wrap pulse.
//
// Parameters:
//   MODULUS  states per digit (2..256)
//   DIGITS   number of cascaded digits (1..8)
//   DW       bits per digit, derived as $clog2(MODULUS)
//
// Ports:
//   clk         rising-edge clock
//   preset      asynchronous active-high preset; every digit = MODULUS-1
//   en          count enable
//   up          direction, 1 = increment, 0 = decrement
//   load        synchronous parallel load (has priority over en)
//   load_value  load data, digit i at [i*DW +: DW]
//   count       current value, digit i at [i*DW +: DW], digit 0 is the LSD
//   tc          terminal count: all digits at MODULUS-1 (up) or 0 (down)
//   carry_out   tc & en, for the en of the next instance
//   wrap        registered pulse for the cycle after a full-range wrap
//
// Build option:
//   CONTADOR_SATURATE_EN  when defined, the counter holds at the boundary
//                         instead of wrapping, and wrap stays 0.
// ---------------------------------------------------------------------------
module contador_modn_updown_cascata #(
  parameter int MODULUS = 10,
  parameter int DIGITS  = 2,
  localparam int DW     = $clog2(MODULUS)
) (
  input  logic                 clk,
  input  logic                 preset,
  input  logic                 en,
  input  logic                 up,
  input  logic                 load,
  input  logic [DIGITS*DW-1:0] load_value,
  output logic [DIGITS*DW-1:0] count,
  output logic                 tc,
  output logic                 carry_out,
  output logic                 wrap
);

  localparam logic [DW-1:0] MAX_VAL = DW'(MODULUS - 1);
  // The modulus is one bit wider than a digit so that a power-of-two
  // MODULUS (e.g. 256 with DW = 8) still compares correctly.
  localparam logic [DW:0]   MOD_EXT = (DW + 1)'(MODULUS);

`ifdef CONTADOR_SATURATE_EN
  localparam logic SATURATE = 1'b1;
`else
  localparam logic SATURATE = 1'b0;
`endif

  logic [DIGITS-1:0][DW-1:0] digit_reg;
  logic [DIGITS-1:0][DW-1:0] digit_next;

  // lower_max[i]  : every digit below i sits at MODULUS-1
  // lower_zero[i] : every digit below i sits at 0
  // Index DIGITS covers the whole counter and so forms tc.
  logic [DIGITS:0] lower_max;
  logic [DIGITS:0] lower_zero;

  logic wrap_next;
  logic hold_at_boundary;

  assign lower_max[0]  = 1'b1;
  assign lower_zero[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic          is_max;
      logic          is_zero;
      logic          step;
      logic [DW-1:0] field;
      logic [DW-1:0] clamped;
      logic [DW-1:0] inc_val;
      logic [DW-1:0] dec_val;

      assign is_max  = (digit_reg[gi] == MAX_VAL);
      assign is_zero = (digit_reg[gi] == '0);

      assign lower_max[gi+1]  = lower_max[gi]  & is_max;
      assign lower_zero[gi+1] = lower_zero[gi] & is_zero;

      // A digit moves only when all lower digits are about to roll over
      // in the current direction; digit 0 has an empty lower set.
      assign step = up ? lower_max[gi] : lower_zero[gi];

      assign field   = load_value[gi*DW +: DW];
      assign clamped = ({1'b0, field} >= MOD_EXT) ? MAX_VAL : field;

      assign inc_val = is_max  ? '0      : digit_reg[gi] + DW'(1);
      assign dec_val = is_zero ? MAX_VAL : digit_reg[gi] - DW'(1);

      assign digit_next[gi] = load ? clamped :
                              (en && step && !hold_at_boundary) ?
                                (up ? inc_val : dec_val) :
                                digit_reg[gi];
    end
  endgenerate

  assign tc        = up ? lower_max[DIGITS] : lower_zero[DIGITS];
  assign carry_out = tc & en;

  // In saturating builds an enabled edge at the boundary is a hold.
  assign hold_at_boundary = SATURATE & tc;

  assign wrap_next = ~load & en & tc & ~SATURATE;

  always_ff @(posedge clk or posedge preset) begin
    if (preset) begin
      for (int i = 0; i < DIGITS; i++) begin
        digit_reg[i] <= MAX_VAL;
      end
      wrap <= 1'b0;
    end else begin
      digit_reg <= digit_next;
      wrap      <= wrap_next;
    end
  end

  assign count = digit_reg;

endmodule

// File: tb/tb_contador_modn_updown_cascata.sv
// ---------------------------------------------------------------------------
// Testbench for contador_modn_updown_cascata (MODULUS=10, DIGITS=2).
// The reference model holds the counter as one integer in 0..MODULUS**DIGITS-1
// and derives digits, tc and wrap from it arithmetically. A negedge process
// compares every output each cycle; directed literal checks pin the model.
// ---------------------------------------------------------------------------
module tb_contador_modn_updown_cascata;

  localparam int MODULUS = 10;
  localparam int DIGITS  = 2;
  localparam int DW      = $clog2(MODULUS);
  localparam int CW      = DIGITS * DW;

`ifdef CONTADOR_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk;
  logic          clk_on;
  logic          preset;
  logic          en;
  logic          up;
  logic          load;
  logic [CW-1:0] load_value;
  logic [CW-1:0] count;
  logic          tc;
  logic          carry_out;
  logic          wrap;

  int n_checks;
  int n_fail;

  contador_modn_updown_cascata #(
    .MODULUS(MODULUS),
    .DIGITS (DIGITS)
  ) dut (
    .clk       (clk),
    .preset    (preset),
    .en        (en),
    .up        (up),
    .load      (load),
    .load_value(load_value),
    .count     (count),
    .tc        (tc),
    .carry_out (carry_out),
    .wrap      (wrap)
  );

  always #5 clk = clk_on ? ~clk : clk;

  // ---------------- reference model ----------------
  function automatic longint range_size();
    longint r = 1;
    for (int i = 0; i < DIGITS; i++) r = r * MODULUS;
    return r;
  endfunction

  function automatic logic [CW-1:0] to_count(input longint v);
    logic [CW-1:0] c = '0;
    longint        t = v;
    for (int i = 0; i < DIGITS; i++) begin
      c[i*DW +: DW] = DW'(t % MODULUS);
      t = t / MODULUS;
    end
    return c;
  endfunction

  function automatic longint load_to_val(input logic [CW-1:0] lv);
    longint v = 0;
    longint w = 1;
    int     f;
    for (int i = 0; i < DIGITS; i++) begin
      f = int'(lv[i*DW +: DW]);
      if (f >= MODULUS) f = MODULUS - 1;
      v = v + longint'(f) * w;
      w = w * MODULUS;
    end
    return v;
  endfunction

  function automatic bit model_tc(input longint v, input logic u);
    return u ? (v == range_size() - 1) : (v == 0);
  endfunction

  longint m_val;
  logic   m_wrap;

  always @(posedge clk or posedge preset) begin
    if (preset) begin
      m_val  <= range_size() - 1;
      m_wrap <= 1'b0;
    end else if (load) begin
      m_val  <= load_to_val(load_value);
      m_wrap <= 1'b0;
    end else if (en) begin
      if (model_tc(m_val, up) && SAT)
        m_val <= m_val;
      else if (up)
        m_val <= (m_val + 1) % range_size();
      else
        m_val <= (m_val + range_size() - 1) % range_size();
      m_wrap <= model_tc(m_val, up) && !SAT;
    end else begin
      m_wrap <= 1'b0;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cyc_count", 64'(count), 64'(to_count(m_val)));
    chk("cyc_tc", 64'(tc), 64'(model_tc(m_val, up)));
    chk("cyc_carry", 64'(carry_out), 64'(model_tc(m_val, up) & en));
    chk("cyc_wrap", 64'(wrap), 64'(m_wrap));
  end

  // Apply inputs, let one rising edge consume them, return 1 ns after it.
  task automatic drive(input logic e, input logic u, input logic l, input logic [CW-1:0] lv);
    en = e; up = u; load = l; load_value = lv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0;
    clk = 0; clk_on = 0; preset = 0;
    en = 0; up = 0; load = 0; load_value = '0;

    // Preset with no clock running.
    #2 preset = 1;
    #2;
    chk("preset_count", 64'(count), 64'h99);
    chk("preset_wrap", 64'(wrap), 64'h0);
    chk("preset_tc_down", 64'(tc), 64'h0);
    clk_on = 1;
    @(posedge clk); #1;
    preset = 0;

    // Enable low: hold.
    for (int i = 0; i < 3; i++) drive(0, 0, 0, '0);
    chk("hold_count", 64'(count), 64'h99);

    // Count down through the full range.
    drive(1, 0, 0, '0);
    chk("down_e1", 64'(count), 64'h98);
    for (int i = 2; i <= 10; i++) drive(1, 0, 0, '0);
    chk("down_e10", 64'(count), 64'h89);
    for (int i = 11; i <= 99; i++) drive(1, 0, 0, '0);
    chk("down_e99", 64'(count), 64'h00);
    chk("down_e99_tc", 64'(tc), 64'h1);
    chk("down_e99_carry", 64'(carry_out), 64'h1);
`ifndef CONTADOR_SATURATE_EN
    drive(1, 0, 0, '0);
    chk("down_e100", 64'(count), 64'h99);
    chk("down_e100_wrap", 64'(wrap), 64'h1);
    drive(0, 0, 0, '0);
    chk("down_wrap_clear", 64'(wrap), 64'h0);
`endif

    // Count up with a digit-1 step.
    drive(0, 1, 1, 8'h00);
    chk("load_00", 64'(count), 64'h00);
    for (int i = 0; i < 9; i++) drive(1, 1, 0, '0);
    chk("up_09", 64'(count), 64'h09);
    drive(1, 1, 0, '0);
    chk("up_10", 64'(count), 64'h10);
    drive(0, 1, 1, 8'h98);
    drive(1, 1, 0, '0);
    chk("up_99", 64'(count), 64'h99);
    chk("up_99_tc", 64'(tc), 64'h1);
`ifdef CONTADOR_SATURATE_EN
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, '0);
      chk("sat_hold", 64'(count), 64'h99);
      chk("sat_wrap", 64'(wrap), 64'h0);
      chk("sat_carry", 64'(carry_out), 64'h1);
    end
    drive(1, 0, 0, '0);
    chk("sat_down", 64'(count), 64'h98);
`else
    drive(1, 1, 0, '0);
    chk("up_wrap_count", 64'(count), 64'h00);
    chk("up_wrap_pulse", 64'(wrap), 64'h1);
`endif

    // Load with clamping; en ignored.
    drive(1, 1, 1, 8'hFA);
    chk("clamp_count", 64'(count), 64'h99);
    chk("clamp_wrap", 64'(wrap), 64'h0);

    // Asynchronous preset mid-count.
    drive(0, 1, 1, 8'h42);
    chk("load_42", 64'(count), 64'h42);
    #2 preset = 1;
    #1;
    chk("async_preset", 64'(count), 64'h99);
    #2 preset = 0;
    drive(1, 0, 0, '0);
    chk("after_preset", 64'(count), 64'h98);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) preset = 1;
      drive(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 15) == 0),
            CW'($urandom));
      preset = 0;
    end

    drive(0, 0, 0, '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
